seg7_bcd_scan: RTL and testbench
================================

# seg7_bcd_scan

Sequential 4-digit multiplexed seven-segment driver for the Basys3 display, sitting directly downstream of the binary-to-BCD converter stage. Captures a 16-bit packed BCD word, applies it at frame boundaries (no tearing), scans the four digits at a fixed refresh rate, and generates active-low anode, segment and decimal-point drives. Includes leading-zero blanking, a dash glyph for invalid nibbles, and a one-cycle ghost-guard between digits.

## Interface
- `DIV`, 100000, clock cycles per digit slot; legal range is 2 or greater (100 MHz clock gives a 1 kHz digit rate and a 250 Hz frame rate).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `bcd`  in  16  packed BCD: [15:12] is digit 3 (leftmost), down to [3:0] for digit 0.
- `load`  in  1  single-cycle strobe; captures `bcd` and `dp_in` into the pending register.
- `blank_lz`  in  1  leading-zero blanking enable; sampled live.
- `dp_in`  in  4  decimal-point request per digit, active-high.
- `an`  out  4  anode enables, active-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse when a pending value is committed to display.

## Operation
- **Prescaler.** `pcnt` counts 0 to DIV-1 and then wraps to 0. `tick` = (`pcnt` == DIV-1).
- **Digit index.** `idx` (2 bits) increments on `tick`, wrapping 3 to 0.
- **Capture.** On `load`, {`bcd`, `dp_in`} is written to the pending register and `pend` is set to 1.
  - A later `load` while `pend` = 1 overwrites the pending register; last value wins.
- **Commit.** On a `tick` with `idx` == 3 and `pend` = 1:
  - the display register takes the pending value;
  - `pend` clears;
  - `frame` pulses the next cycle.
- **Load/commit collision.** If `load` and the commit condition occur in the same cycle:
  - the commit uses the old pending value;
  - the new value becomes pending and `pend` stays 1.
- **Glyphs.** Nibbles 0–9 use the standard glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10–15 show a dash, 0111111.
- **Leading-zero blanking** (when `blank_lz` = 1):
  - digit 3 is blanked if it is 0;
  - digit 2 is blanked if digits 3 and 2 are both 0;
  - digit 1 is blanked if digits 3..1 are all 0;
  - digit 0 is never blanked.
  - A blanked digit keeps its `an` bit high, `seg` = 1111111 and `dp` = 1, even if its dp request is set.
- **Ghost guard.** In the cycle after each `tick`, `an` = 1111 and `seg`/`dp` take the new digit's values. The new digit's anode asserts one cycle later.

## Timing
- **Reset values:** `an`=1111, `seg`=1111111, `dp`=1, `frame`=0, `pcnt`=0, `idx`=0, `pend`=0, display and pending registers 0.
- **First digit after reset release:** the first clock edge with `rst` low is edge 1. `an` = 1110 from edge 1 onward, showing digit 0 of value 0 as "0" (or as blank-free "0" with `blank_lz` = 1).
- **Registered outputs:**
  - `tick` is high in cycle t;
  - cycle t+1: `an` = 1111, `seg`/`dp` are the new digit's values;
  - cycle t+2 to the next tick: `an` has one bit low (bit `idx`).
- **Load-to-display latency:** varies, at most 4·DIV+2 cycles. The value appears on digit 0 at t+2 of the commit tick.
- **Decoder output timing:** `blank_lz` and invalid-nibble decode affect outputs with a one-cycle register latency.
- **Reset mid-scan:** all state returns to reset values on the next edge. Any pending value is lost and `frame` is suppressed.
- **`DIV` = 2:** the prescaler alternates, and each digit is lit for exactly 1 cycle per slot after the guard cycle.

## Structure
- **Package `seg7_pkg`:**
  - segment glyph constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`);
  - `DIV` default;
  - anode-off constant 4'b1111.
- **Sub-module `bcd_to_seg7`:** purely combinational, 4-bit nibble in, 7-bit active-low glyph out, invalid input gives dash. It is instantiated once on the muxed nibble.
- **Top level:** prescaler, index counter, pending/display registers, blanking logic and output registers.

## Test plan
- **Reset:** hold `rst` 3 cycles → `an`=1111, `seg`=1111111, `dp`=1, `frame`=0. Release → `an`=1110 after one edge.
- **Basic scan:** `DIV`=4, load 0x1234, `blank_lz`=0 → `frame` pulses.
  - Expect the sequence digit0 "4", digit1 "3", digit2 "2", digit3 "1", each 3 lit cycles after a 1-cycle `an`=1111 guard.
- **Leading-zero blanking:** load 0x0070 with `blank_lz`=1 → digits 3 and 2 keep their `an` bits high; digit 1 shows 1111000 and digit 0 shows 1000000. With `blank_lz`=0, digits 3 and 2 show 1000000.
- **Invalid nibble and dp:** load 0xA5F9 with `dp_in`=0100 → digits 3 and 1 show 0111111, and `dp`=0 only while `an`=1011.
- **Load collision and overwrite:**
  - load 0x1111, then 0x2222 before the commit → only 0x2222 is displayed, with a single `frame` pulse.
  - `load` of 0x3333 on the commit cycle → 0x2222 shows this frame, 0x3333 shows next frame, then `pend`=0.
- **Reset mid-frame:** assert `rst` during a digit-2 slot with a pending value → reset values, and no later display of the discarded value.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the Basys3 seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned DIV_DEFAULT = 100000;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // One display frame: four BCD digits plus per-digit decimal-point requests
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_word_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph; 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous update,
// leading-zero blanking and a one-cycle anode guard between digits.
module seg7_bcd_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int unsigned     PW        = $clog2(DIV);
  localparam logic [PW-1:0]   PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic          pend;
  disp_word_t    pend_word;
  disp_word_t    disp_word;

  logic          tick;
  logic          commit;
  logic [1:0]    idx_nxt;
  disp_word_t    disp_nxt;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          dp_req;
  logic          lz_zero;
  logic          blanked;
  logic [3:0]    an_sel;

  assign tick   = (pcnt == PCNT_LAST);
  assign commit = tick && (idx == 2'd3) && pend;

  // Output registers are fed from the post-edge digit and display word so
  // the new digit's glyph is already present during the guard cycle.
  always_comb begin
    idx_nxt  = tick ? idx + 2'd1 : idx;
    disp_nxt = commit ? pend_word : disp_word;
    nib      = disp_nxt.bcd[{idx_nxt, 2'b00} +: 4];
    dp_req   = disp_nxt.dp[idx_nxt];
    an_sel   = ~(4'b0001 << idx_nxt);
  end

  // Leading-zero detection for the selected digit; digit 0 always shows
  always_comb begin
    lz_zero = 1'b0;
    case (idx_nxt)
      2'd3: lz_zero = (disp_nxt.bcd[15:12] == 4'd0);
      2'd2: lz_zero = (disp_nxt.bcd[15:8]  == 8'd0);
      2'd1: lz_zero = (disp_nxt.bcd[15:4]  == 12'd0);
      default: lz_zero = 1'b0;
    endcase
    blanked = blank_lz && lz_zero;
  end

  bcd_to_seg7 u_dec (
    .nibble (nib),
    .seg    (glyph)
  );

  // Refresh prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      idx  <= idx_nxt;
    end
  end

  // Pending capture and frame-boundary commit; a load coinciding with the
  // commit lands in pending while the commit takes the older value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_word <= '0;
      disp_word <= '0;
    end else begin
      disp_word <= disp_nxt;
      if (load) begin
        pend_word <= '{bcd: bcd, dp: dp_in};
        pend      <= 1'b1;
      end else if (commit) begin
        pend      <= 1'b0;
      end
    end
  end

  // Registered active-low drives and frame strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      frame <= commit;
      if (blanked) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= tick ? AN_OFF : an_sel;
        seg <= glyph;
        dp  <= ~dp_req;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed self-checking bench for seg7_bcd_scan with DIV = 4.
module tb_seg7_bcd_scan;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] G7   = 7'b1111000;
  localparam logic [6:0] G9   = 7'b0010000;
  localparam logic [6:0] GD   = 7'b0111111;
  localparam logic [6:0] GOFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned frame_cnt = 0;
  int unsigned cnt0;

  seg7_bcd_scan #(.DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd      (bcd),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_in    (dp_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame === 1'b1) frame_cnt <= frame_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input logic [15:0] val, input logic [3:0] dpv);
    bcd   = val;
    dp_in = dpv;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int unsigned n = 0;
    while (frame !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_frame"}, {31'd0, frame}, 32'd1);
  endtask

  // Entered on the guard cycle of digit 0 (frame high); walks one full frame
  // and returns on the guard cycle of the following frame.
  task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                             input logic [3:0] exp_lit, input logic [3:0] exp_dp);
    logic [3:0] on_an;
    for (int k = 0; k < 4; k++) begin
      on_an = ~(4'b0001 << k);
      for (int c = 0; c < 4; c++) begin
        check_eq($sformatf("%s_seg_d%0d_c%0d", tag, k, c), {25'd0, seg}, {25'd0, exp_seg[k*7 +: 7]});
        if (c == 0) begin
          check_eq($sformatf("%s_guard_d%0d", tag, k), {28'd0, an}, 32'hF);
        end else begin
          check_eq($sformatf("%s_an_d%0d_c%0d", tag, k, c), {28'd0, an},
                   {28'd0, exp_lit[k] ? on_an : 4'b1111});
          check_eq($sformatf("%s_dp_d%0d_c%0d", tag, k, c), {31'd0, dp},
                   {31'd0, (exp_lit[k] && exp_dp[k]) ? 1'b0 : 1'b1});
        end
        if (k == 0 && c == 1) check_eq({tag, "_frame_one_cycle"}, {31'd0, frame}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bcd = '0; load = 1'b0; blank_lz = 1'b0; dp_in = '0;

    // Reset
    repeat (3) @(negedge clk);
    check_eq("rst_an",    {28'd0, an},    32'hF);
    check_eq("rst_seg",   {25'd0, seg},   32'h7F);
    check_eq("rst_dp",    {31'd0, dp},    32'd1);
    check_eq("rst_frame", {31'd0, frame}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_an",  {28'd0, an},  32'hE);
    check_eq("rel_seg", {25'd0, seg}, {25'd0, G0});
    check_eq("rel_dp",  {31'd0, dp},  32'd1);

    // Basic scan
    do_load(16'h1234, 4'b0000);
    wait_frame("basic");
    check_frame("basic", {G1, G2, G3, G4}, 4'b1111, 4'b0000);

    // Leading-zero blanking on, then off
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    wait_frame("lz_on");
    check_frame("lz_on", {GOFF, GOFF, G7, G0}, 4'b0011, 4'b0000);
    blank_lz = 1'b0;
    do_load(16'h0070, 4'b0000);
    wait_frame("lz_off");
    check_frame("lz_off", {G0, G0, G7, G0}, 4'b1111, 4'b0000);

    // Invalid nibbles and decimal point
    do_load(16'hA5F9, 4'b0100);
    wait_frame("inv");
    check_frame("inv", {GD, G5, GD, G9}, 4'b1111, 4'b0100);

    // Overwrite before commit: last value wins, one frame pulse
    cnt0 = frame_cnt;
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    wait_frame("ovw");
    check_frame("ovw", {G2, G2, G2, G2}, 4'b1111, 4'b0000);
    check_eq("ovw_frame_count", frame_cnt - cnt0, 32'd1);

    // Load on the commit cycle: now at the guard cycle, commit tick is 15 cycles ahead
    cnt0 = frame_cnt;
    do_load(16'h2222, 4'b0000);
    repeat (14) @(negedge clk);
    do_load(16'h3333, 4'b0000);
    wait_frame("col_a");
    check_frame("col_a", {G2, G2, G2, G2}, 4'b1111, 4'b0000);
    wait_frame("col_b");
    check_frame("col_b", {G3, G3, G3, G3}, 4'b1111, 4'b0000);
    repeat (16) @(negedge clk);
    check_eq("col_frame_count", frame_cnt - cnt0, 32'd2);

    // Reset mid-frame during digit 2 with a pending value
    do_load(16'h5555, 4'b0000);
    repeat (8) @(negedge clk);
    check_eq("mid_an_d2",  {28'd0, an},  32'hB);
    check_eq("mid_seg_d2", {25'd0, seg}, {25'd0, G3});
    cnt0 = frame_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_an",    {28'd0, an},    32'hF);
    check_eq("mid_rst_seg",   {25'd0, seg},   32'h7F);
    check_eq("mid_rst_dp",    {31'd0, dp},    32'd1);
    check_eq("mid_rst_frame", {31'd0, frame}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rel_an", {28'd0, an}, 32'hE);
    for (int i = 0; i < 40; i++) begin
      check_eq($sformatf("mid_post_seg_%0d", i), {25'd0, seg}, {25'd0, G0});
      @(negedge clk);
    end
    check_eq("mid_no_frame", frame_cnt - cnt0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
